// File: rtl/cpu_pkg.sv
// Constants and encodings shared by the 6-bit CPU and its boot loader.
// Holds the memory geometry, the loader state codes, the opcode field and the header check.
package cpu_pkg;

    localparam int ADDR_W = 3;
    localparam int INS_W  = 17;
    localparam int DEPTH  = 2 ** ADDR_W;

    typedef logic [2:0] ld_state_t;

    localparam ld_state_t ST_IDLE  = 3'd0;
    localparam ld_state_t ST_HDR   = 3'd1;
    localparam ld_state_t ST_RECV  = 3'd2;
    localparam ld_state_t ST_WRITE = 3'd3;
    localparam ld_state_t ST_CHK   = 3'd4;
    localparam ld_state_t ST_RUN   = 3'd5;
    localparam ld_state_t ST_ERROR = 3'd6;

    // Opcode lives in the top bits of an instruction word; the CPU decoder uses the same field
    localparam int             OP_W   = 5;
    localparam logic [OP_W-1:0] OP_ADD = 5'h0A;
    localparam logic [OP_W-1:0] OP_JMP = 5'h10;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [INS_W-1:0]  data;
    } mem_write_t;

    function automatic logic [OP_W-1:0] opcode_of(input logic [INS_W-1:0] ins);
        return ins[INS_W-1 -: OP_W];
    endfunction

    // A frame may carry 1..DEPTH words
    function automatic logic hdr_ok(input logic [3:0] n);
        return (n != 4'd0) && (n <= 4'(DEPTH));
    endfunction

endpackage

// File: rtl/program_loader.sv
// Boot loader: takes a framed byte stream, writes 17-bit words into CPU instruction
// memory, verifies the XOR checksum and then releases the CPU through pc_en.
module program_loader
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              we,
    output logic [ADDR_W-1:0] wr,
    output logic [INS_W-1:0]  wrd,
    output logic              pc_en,
    output logic              busy,
    output logic              err
);

    ld_state_t         state;
    logic [1:0]        byte_cnt;
    logic [ADDR_W:0]   word_cnt;
    logic [ADDR_W:0]   n_words;
    logic [7:0]        xor_acc;
    // Only b2[0] and b1 are needed once b0 arrives; b2[7:1] only feeds the checksum
    logic [8:0]        word_hi;
    logic              xfer;

    assign xfer = in_valid && in_ready;

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        in_ready = 1'b0;
        we       = 1'b0;
        pc_en    = 1'b0;
        busy     = 1'b0;
        err      = 1'b0;
        case (state)
            ST_HDR, ST_RECV, ST_CHK: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            ST_WRITE: begin
                we   = 1'b1;
                busy = 1'b1;
            end
            ST_RUN:   pc_en = 1'b1;
            ST_ERROR: err   = 1'b1;
            default: ;
        endcase
    end

    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            byte_cnt <= '0;
            word_cnt <= '0;
            n_words  <= '0;
            xor_acc  <= '0;
            word_hi  <= '0;
            wr       <= '0;
            wrd      <= '0;
        end else if (start) begin
            state    <= ST_HDR;
            byte_cnt <= '0;
            word_cnt <= '0;
            xor_acc  <= '0;
        end else begin
            case (state)
                ST_HDR: if (xfer) begin
                    xor_acc  <= in_data;
                    n_words  <= in_data[ADDR_W:0];
                    byte_cnt <= '0;
                    word_cnt <= '0;
                    state    <= hdr_ok(in_data[3:0]) ? ST_RECV : ST_ERROR;
                end
                ST_RECV: if (xfer) begin
                    xor_acc <= xor_acc ^ in_data;
                    if (byte_cnt == 2'd2) begin
                        // wr/wrd are captured here and then hold until the next word completes
                        byte_cnt <= '0;
                        wr       <= word_cnt[ADDR_W-1:0];
                        wrd      <= {word_hi, in_data};
                        state    <= ST_WRITE;
                    end else begin
                        byte_cnt <= byte_cnt + 2'd1;
                        word_hi  <= {word_hi[0], in_data};
                    end
                end
                ST_WRITE: begin
                    if (word_cnt == n_words - 1'b1) begin
                        state <= ST_CHK;
                    end else begin
                        word_cnt <= word_cnt + 1'b1;
                        state    <= ST_RECV;
                    end
                end
                ST_CHK: if (xfer) begin
                    state <= (in_data == xor_acc) ? ST_RUN : ST_ERROR;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: expected memory writes are queued as bytes are
// driven and matched against each we pulse; status outputs are checked after each frame.
module tb_program_loader;
    import cpu_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              we;
    logic [ADDR_W-1:0] wr;
    logic [INS_W-1:0]  wrd;
    logic              pc_en;
    logic              busy;
    logic              err;

    int checks = 0;
    int errors = 0;
    int n_writes = 0;
    logic we_prev = 1'b0;
    mem_write_t sb[$];
    logic [INS_W-1:0] mem [DEPTH];

    program_loader dut (
        .clk(clk), .rst(rst), .start(start),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .we(we), .wr(wr), .wrd(wrd),
        .pc_en(pc_en), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Write monitor: each we pulse must match the head of the scoreboard
    always @(negedge clk) begin
        if (!rst && we) begin
            if (sb.size() == 0) begin
                check("unexpected_we", 32'(we), 32'd0);
            end else begin
                mem_write_t e;
                e = sb.pop_front();
                check("wr", 32'(wr), 32'(e.addr));
                check("wrd", 32'(wrd), 32'(e.data));
            end
            check("we_single_cycle", 32'(we_prev), 32'd0);
            check("we_while_ready", 32'(in_ready), 32'd0);
            mem[wr] = wrd;
            n_writes++;
        end
        if (!rst && pc_en)
            check("pc_en_with_busy", 32'(busy), 32'd0);
        we_prev = rst ? 1'b0 : we;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int n;
        if (gaps) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        in_data  = b;
        in_valid = 1'b1;
        n = 0;
        while (in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("handshake_in_budget", 32'(n < 100), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic push_write(input int addr, input logic [INS_W-1:0] data);
        mem_write_t e;
        e.addr = ADDR_W'(addr);
        e.data = data;
        sb.push_back(e);
    endtask

    // Sends header, words (stopping early if stop_after < size) and checksum
    task automatic send_frame(input logic [INS_W-1:0] w[$], input bit bad_ck,
                              input bit gaps, input int stop_after);
        logic [7:0] ck, b2, b1, b0;
        ck = 8'(w.size());
        send_byte(ck, gaps);
        for (int i = 0; i < w.size(); i++) begin
            if (i == stop_after) return;
            b2 = {(gaps ? 7'($urandom) : 7'd0), w[i][16]};
            b1 = w[i][15:8];
            b0 = w[i][7:0];
            push_write(i, w[i]);
            send_byte(b2, gaps);
            send_byte(b1, gaps);
            send_byte(b0, gaps);
            ck = ck ^ b2 ^ b1 ^ b0;
        end
        send_byte(bad_ck ? (ck ^ 8'h01) : ck, gaps);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!(pc_en || err) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("done_in_budget", 32'(n < 50), 32'd1);
    endtask

    initial begin
        logic [7:0] t1 [14];
        logic [INS_W-1:0] words[$];
        int w0;

        t1 = '{8'h04, 8'h00, 8'hA0, 8'h50, 8'h00, 8'hA4, 8'h40,
               8'h00, 8'h20, 8'h80, 8'h01, 8'h00, 8'h00, 8'hB1};

        // Reset values
        #3;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_we", 32'(we), 32'd0);
        check("rst_wr", 32'(wr), 32'd0);
        check("rst_wrd", 32'(wrd), 32'd0);
        check("rst_pc_en", 32'(pc_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", 32'(in_ready), 32'd0);

        // Test 1: reference program from literal bytes
        push_write(0, 17'h0A050);
        push_write(1, 17'h0A440);
        push_write(2, 17'h02080);
        push_write(3, 17'h10000);
        w0 = n_writes;
        pulse_start();
        check("hdr_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 14; i++) send_byte(t1[i], 1'b0);
        wait_done();
        check("t1_writes", 32'(n_writes - w0), 32'd4);
        check("t1_sb_empty", 32'(sb.size()), 32'd0);
        check("t1_pc_en", 32'(pc_en), 32'd1);
        check("t1_err", 32'(err), 32'd0);
        check("t1_busy", 32'(busy), 32'd0);
        check("t1_opcode_add", 32'(opcode_of(mem[0])), 32'(OP_ADD));
        check("t1_opcode_jmp", 32'(opcode_of(mem[3])), 32'(OP_JMP));

        // Test 2: same frame, wrong checksum
        push_write(0, 17'h0A050);
        push_write(1, 17'h0A440);
        push_write(2, 17'h02080);
        push_write(3, 17'h10000);
        w0 = n_writes;
        pulse_start();
        check("restart_pc_en_low", 32'(pc_en), 32'd0);
        for (int i = 0; i < 13; i++) send_byte(t1[i], 1'b0);
        send_byte(8'hB0, 1'b0);
        wait_done();
        check("t2_writes", 32'(n_writes - w0), 32'd4);
        check("t2_err", 32'(err), 32'd1);
        check("t2_pc_en", 32'(pc_en), 32'd0);
        repeat (3) @(negedge clk);
        check("t2_err_sticky", 32'(err), 32'd1);

        // Test 3: illegal headers 0x00 and 0x09
        w0 = n_writes;
        pulse_start();
        check("start_clears_err", 32'(err), 32'd0);
        send_byte(8'h00, 1'b0);
        check("t3_hdr00_err", 32'(err), 32'd1);
        check("t3_hdr00_ready", 32'(in_ready), 32'd0);
        pulse_start();
        send_byte(8'h09, 1'b0);
        check("t3_hdr09_err", 32'(err), 32'd1);
        check("t3_hdr09_pc_en", 32'(pc_en), 32'd0);
        check("t3_writes", 32'(n_writes - w0), 32'd0);

        // Test 4: full 8-word frame with random valid gaps and junk b2 bits
        words.delete();
        for (int i = 0; i < DEPTH; i++) words.push_back(17'($urandom));
        w0 = n_writes;
        pulse_start();
        send_frame(words, 1'b0, 1'b1, 99);
        wait_done();
        check("t4_writes", 32'(n_writes - w0), 32'd8);
        check("t4_sb_empty", 32'(sb.size()), 32'd0);
        check("t4_pc_en", 32'(pc_en), 32'd1);
        check("t4_err", 32'(err), 32'd0);

        // Test 5: abort after the 2nd word, then a full new frame
        words.delete();
        for (int i = 0; i < 4; i++) words.push_back(17'h1F000 + 17'(i));
        pulse_start();
        send_frame(words, 1'b0, 1'b0, 2);
        @(negedge clk);
        words.delete();
        words = '{17'h00123, 17'h1ABCD, 17'h05555, 17'h0FFFF};
        pulse_start();
        send_frame(words, 1'b0, 1'b0, 99);
        wait_done();
        check("t5_sb_empty", 32'(sb.size()), 32'd0);
        check("t5_pc_en", 32'(pc_en), 32'd1);
        check("t5_err", 32'(err), 32'd0);
        for (int i = 0; i < 4; i++)
            check($sformatf("t5_mem%0d", i), 32'(mem[i]), 32'(words[i]));

        // Test 6a: reset asserted during a WRITE cycle
        pulse_start();
        send_byte(8'h02, 1'b0);
        push_write(0, 17'h13579);
        send_byte(8'h01, 1'b0);
        send_byte(8'h35, 1'b0);
        send_byte(8'h79, 1'b0);
        check("t6_in_write", 32'(we), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("t6_rst_we", 32'(we), 32'd0);
        check("t6_rst_wr", 32'(wr), 32'd0);
        check("t6_rst_wrd", 32'(wrd), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_ready", 32'(in_ready), 32'd0);
        check("t6_rst_err", 32'(err), 32'd0);
        w0 = n_writes;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("t6_no_writes_after_rst", 32'(n_writes - w0), 32'd0);

        // Test 6b: start in RUN drops pc_en on the next edge
        words.delete();
        words = '{17'h0A050, 17'h10000};
        pulse_start();
        send_frame(words, 1'b0, 1'b0, 99);
        wait_done();
        check("t6_run_pc_en", 32'(pc_en), 32'd1);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        check("t6_start_pc_en", 32'(pc_en), 32'd0);
        check("t6_start_busy", 32'(busy), 32'd1);
        @(negedge clk);
        start = 1'b0;
        check("t6_sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
